// File: rtl/batalha_pkg.sv
// Shared constants and types for the 5x7 naval-battle board.
package batalha_pkg;

  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 7;
  localparam int COORD_W  = 3;
  localparam int VIDA_W   = 3;
  localparam logic [VIDA_W-1:0] VIDA_MAX = 3'd7;

  // One board column; bit r is row r.
  typedef logic [NUM_ROWS-1:0] coluna_t;

endpackage

// File: rtl/comparador_de_igualdade.sv
// Combinational equality of two board columns.
module comparador_de_igualdade
  import batalha_pkg::*;
(
  input  coluna_t a,
  input  coluna_t b,
  output logic    igual
);

  assign igual = (a == b);

endmodule

// File: rtl/contador_vida.sv
// Miss counter: saturating increment, synchronous clear, async reset.
module contador_vida
  import batalha_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              inc,
  input  logic              clear,
  output logic [VIDA_W-1:0] S
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      S <= '0;
    end else if (clear) begin
      S <= '0;
    end else if (inc && (S != VIDA_MAX)) begin
      S <= S + 1'b1;
    end
  end

endmodule

// File: rtl/decodificador_3bits.sv
// Combinational 3-to-8 one-hot decoder.
module decodificador_3bits (
  input  logic [2:0] a,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic       s4,
  output logic       s5,
  output logic       s6,
  output logic       s7
);

  assign s0 = (a == 3'd0);
  assign s1 = (a == 3'd1);
  assign s2 = (a == 3'd2);
  assign s3 = (a == 3'd3);
  assign s4 = (a == 3'd4);
  assign s5 = (a == 3'd5);
  assign s6 = (a == 3'd6);
  assign s7 = (a == 3'd7);

endmodule

// File: rtl/gerenciador_ataque.sv
// Attack manager: evaluates confirmed shots against the hidden map,
// reveals hits, drives status LEDs and counts misses.
module gerenciador_ataque
  import batalha_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               confirmar,
  input  logic [COORD_W-1:0] coordColuna,
  input  logic [COORD_W-1:0] coordLinha,
  input  coluna_t            mapa0,
  input  coluna_t            mapa1,
  input  coluna_t            mapa2,
  input  coluna_t            mapa3,
  input  coluna_t            mapa4,
  output coluna_t            matriz0,
  output coluna_t            matriz1,
  output coluna_t            matriz2,
  output coluna_t            matriz3,
  output coluna_t            matriz4,
  output logic               LED_R,
  output logic               LED_G,
  output logic               LED_B,
  output logic [VIDA_W-1:0]  vida
);

  logic                confirmar_q;
  logic                fire;
  logic [7:0]          col_sel;
  logic [7:0]          row_sel;
  logic                alvo_valido;
  coluna_t             mapa_v     [NUM_COLS];
  coluna_t             matriz_r   [NUM_COLS];
  coluna_t             matriz_nxt [NUM_COLS];
  logic [NUM_COLS-1:0] igual;
  logic                miss;

  assign fire = confirmar & ~confirmar_q & enable;

  assign mapa_v[0] = mapa0;
  assign mapa_v[1] = mapa1;
  assign mapa_v[2] = mapa2;
  assign mapa_v[3] = mapa3;
  assign mapa_v[4] = mapa4;

  decodificador_3bits u_dec_col (
    .a (coordColuna),
    .s0(col_sel[0]), .s1(col_sel[1]), .s2(col_sel[2]), .s3(col_sel[3]),
    .s4(col_sel[4]), .s5(col_sel[5]), .s6(col_sel[6]), .s7(col_sel[7])
  );

  decodificador_3bits u_dec_row (
    .a (coordLinha),
    .s0(row_sel[0]), .s1(row_sel[1]), .s2(row_sel[2]), .s3(row_sel[3]),
    .s4(row_sel[4]), .s5(row_sel[5]), .s6(row_sel[6]), .s7(row_sel[7])
  );

  // Off-board coordinates select no cell, so they fall through as misses.
  assign alvo_valido = ~(|col_sel[7:NUM_COLS]) & ~row_sel[7];

  always_comb begin
    for (int c = 0; c < NUM_COLS; c++) begin
      matriz_nxt[c] = matriz_r[c]
                    | (mapa_v[c] & row_sel[NUM_ROWS-1:0]
                       & {NUM_ROWS{col_sel[c] & alvo_valido}});
    end
  end

  // A shot is a hit exactly when it changes some column of the matrix.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_cmp
    comparador_de_igualdade u_cmp (
      .a    (matriz_r[c]),
      .b    (matriz_nxt[c]),
      .igual(igual[c])
    );
  end

  assign miss = &igual;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      confirmar_q <= 1'b0;
      LED_R       <= 1'b0;
      LED_G       <= 1'b0;
      for (int c = 0; c < NUM_COLS; c++) matriz_r[c] <= '0;
    end else begin
      confirmar_q <= confirmar;
      if (!enable) begin
        LED_R <= 1'b0;
        LED_G <= 1'b0;
        for (int c = 0; c < NUM_COLS; c++) matriz_r[c] <= '0;
      end else if (fire) begin
        LED_R <= miss;
        LED_G <= ~miss;
        for (int c = 0; c < NUM_COLS; c++) matriz_r[c] <= matriz_nxt[c];
      end
    end
  end

  contador_vida u_vida (
    .clock(clock),
    .reset(reset),
    .inc  (fire & miss),
    .clear(~enable),
    .S    (vida)
  );

  assign matriz0 = matriz_r[0];
  assign matriz1 = matriz_r[1];
  assign matriz2 = matriz_r[2];
  assign matriz3 = matriz_r[3];
  assign matriz4 = matriz_r[4];
  assign LED_B   = 1'b0;

endmodule

// File: tb/tb_gerenciador_ataque.sv
// Self-checking bench for gerenciador_ataque: directed plan plus random shots
// against a cell-level reference model.
module tb_gerenciador_ataque;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       confirmar;
  logic [2:0] coord_col;
  logic [2:0] coord_lin;
  logic [6:0] mapa [5];
  logic [6:0] matriz0, matriz1, matriz2, matriz3, matriz4;
  logic       led_r, led_g, led_b;
  logic [2:0] vida;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [6:0] exp_mat [5];
  logic       exp_r, exp_g;
  int         exp_vida;

  gerenciador_ataque dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .confirmar  (confirmar),
    .coordColuna(coord_col),
    .coordLinha (coord_lin),
    .mapa0      (mapa[0]),
    .mapa1      (mapa[1]),
    .mapa2      (mapa[2]),
    .mapa3      (mapa[3]),
    .mapa4      (mapa[4]),
    .matriz0    (matriz0),
    .matriz1    (matriz1),
    .matriz2    (matriz2),
    .matriz3    (matriz3),
    .matriz4    (matriz4),
    .LED_R      (led_r),
    .LED_G      (led_g),
    .LED_B      (led_b),
    .vida       (vida)
  );

  // Clock / watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_matriz0"}, 32'(matriz0), 32'(exp_mat[0]));
    check({tag, "_matriz1"}, 32'(matriz1), 32'(exp_mat[1]));
    check({tag, "_matriz2"}, 32'(matriz2), 32'(exp_mat[2]));
    check({tag, "_matriz3"}, 32'(matriz3), 32'(exp_mat[3]));
    check({tag, "_matriz4"}, 32'(matriz4), 32'(exp_mat[4]));
    check({tag, "_led_r"},   32'(led_r),   32'(exp_r));
    check({tag, "_led_g"},   32'(led_g),   32'(exp_g));
    check({tag, "_led_b"},   32'(led_b),   32'd0);
    check({tag, "_vida"},    32'(vida),    32'(exp_vida));
  endtask

  // Model: board cleared
  task automatic model_clear();
    for (int c = 0; c < 5; c++) exp_mat[c] = '0;
    exp_r    = 1'b0;
    exp_g    = 1'b0;
    exp_vida = 0;
  endtask

  // Model: one fired shot at (c, r) using the map as it stands right now
  task automatic model_shot(input int c, input int r);
    if (c < 5 && r < 7 && mapa[c][r] && !exp_mat[c][r]) begin
      exp_mat[c][r] = 1'b1;
      exp_g = 1'b1;
      exp_r = 1'b0;
    end else begin
      exp_g = 1'b0;
      exp_r = 1'b1;
      if (exp_vida < 7) exp_vida++;
    end
  endtask

  // Driver: one press-and-release of the fire button
  task automatic shot(input int c, input int r, input string tag);
    @(posedge clock); #1;
    coord_col = c[2:0];
    coord_lin = r[2:0];
    confirmar = 1'b1;
    @(posedge clock); #1;
    model_shot(c, r);
    confirmar = 1'b0;
    coord_col = 3'($urandom_range(0, 7));
    coord_lin = 3'($urandom_range(0, 7));
    check_all(tag);
    @(posedge clock); #1;
  endtask

  task automatic hold_shot(input int c, input int r, input int cycles, input string tag);
    @(posedge clock); #1;
    coord_col = c[2:0];
    coord_lin = r[2:0];
    confirmar = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      if (i == 0) model_shot(c, r);
      check_all(tag);
    end
    confirmar = 1'b0;
    @(posedge clock); #1;
    check_all({tag, "_rel"});
  endtask

  task automatic drop_enable(input string tag);
    @(posedge clock); #1;
    enable = 1'b0;
    @(posedge clock); #1;
    model_clear();
    enable = 1'b1;
    check_all(tag);
  endtask

  task automatic set_plan_map();
    mapa[0] = 7'b1110001;
    mapa[1] = 7'b0100000;
    mapa[2] = 7'b0000000;
    mapa[3] = 7'b0000000;
    mapa[4] = 7'b1110000;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    confirmar = 1'b0;
    coord_col = '0;
    coord_lin = '0;
    set_plan_map();
    model_clear();
    #3;
    check_all("reset");
    @(posedge clock); #1;
    reset  = 1'b0;
    enable = 1'b1;
    @(posedge clock); #1;
    check_all("idle");

    // 1-4: hits, misses, re-fire, off-board coordinates
    shot(0, 0, "hit_c0r0");
    shot(0, 1, "miss_c0r1");
    shot(3, 5, "miss_c3r5");
    shot(1, 5, "hit_c1r5");
    shot(4, 6, "hit_c4r6");
    shot(0, 0, "refire_c0r0");
    shot(5, 0, "miss_col5");
    shot(0, 7, "miss_row7");

    // 5: held button fires once, then saturation
    hold_shot(4, 5, 5, "hold_c4r5");
    for (int i = 0; i < 8; i++) shot(2, i % 7, "sat_miss");
    check("vida_saturated", 32'(vida), 32'd7);

    // Map change alone never alters the matrix
    @(posedge clock); #1;
    mapa[2] = 7'b1111111;
    @(posedge clock); #1;
    check_all("map_change_idle");
    shot(2, 3, "hit_new_map");
    set_plan_map();

    // 6: enable low clears everything
    drop_enable("enable_low");

    // Randomized shots, map changes and enable drops
    for (int n = 0; n < 150; n++) begin
      int op;
      op = int'($urandom_range(0, 19));
      if (op == 0) begin
        drop_enable("rnd_enable");
      end else if (op < 4) begin
        int c;
        c = int'($urandom_range(0, 4));
        mapa[c] = 7'($urandom);
      end else if (op == 4) begin
        hold_shot(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(2, 4)), "rnd_hold");
      end else begin
        shot(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), "rnd_shot");
      end
    end

    // Async reset mid-cycle clears before any clock edge
    set_plan_map();
    shot(0, 4, "pre_areset");
    shot(0, 3, "pre_areset2");
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    model_clear();
    check_all("async_reset");

    // Confirmar held high through reset release fires exactly once
    confirmar = 1'b1;
    coord_col = 3'd4;
    coord_lin = 3'd4;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    model_shot(4, 4);
    check_all("held_through_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check_all("held_through_reset_hold");
    end
    confirmar = 1'b0;
    @(posedge clock); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
